// File: rtl/spi_config_master.sv
// SPI mode-0 configuration master: streams FRAME_BYTES bytes per SS-low frame, MSB first.
// Optional MISO capture into rx_data/rx_valid is enabled by defining SPI_MISO_CAPTURE_EN.
module spi_config_master #(
  parameter int unsigned CLK_DIV     = 4,
  parameter int unsigned FRAME_BYTES = 215
) (
  input  logic       system_clock,
  input  logic       reset,
  input  logic       start,
  input  logic       abort,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       busy,
  output logic       done,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       SCLK,
  output logic       MOSI,
  output logic       SS,
  input  logic       MISO
);

  localparam int unsigned CW       = $clog2(FRAME_BYTES + 1);
  localparam logic [7:0]  DIV_LAST = 8'(CLK_DIV - 1);

  typedef enum logic [2:0] {IDLE, SETUP, LOAD, SHIFT, HOLD} state_t;

  state_t          state_q, state_d;
  logic [7:0]      div_q, div_d;
  logic [2:0]      bit_q, bit_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [7:0]      sr_q, sr_d;
  logic            sclk_q, sclk_d;
  logic            ss_q, ss_d;
  logic            done_q, done_d;
  logic            div_last;

`ifdef SPI_MISO_CAPTURE_EN
  logic [7:0]      rxsr_q, rxsr_d;
  logic [7:0]      rxd_q, rxd_d;
  logic            rxv_q, rxv_d;
`endif

  assign div_last = (div_q == DIV_LAST);

  always_ff @(posedge system_clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      div_q   <= '0;
      bit_q   <= '0;
      cnt_q   <= '0;
      sr_q    <= '0;
      sclk_q  <= 1'b0;
      ss_q    <= 1'b1;
      done_q  <= 1'b0;
`ifdef SPI_MISO_CAPTURE_EN
      rxsr_q  <= '0;
      rxd_q   <= '0;
      rxv_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      cnt_q   <= cnt_d;
      sr_q    <= sr_d;
      sclk_q  <= sclk_d;
      ss_q    <= ss_d;
      done_q  <= done_d;
`ifdef SPI_MISO_CAPTURE_EN
      rxsr_q  <= rxsr_d;
      rxd_q   <= rxd_d;
      rxv_q   <= rxv_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    if (state_q != IDLE && abort) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE:  if (start && !abort) state_d = SETUP;
        SETUP: if (div_last) state_d = LOAD;
        LOAD:  if (tx_valid) state_d = SHIFT;
        SHIFT: if (div_last && sclk_q && bit_q == 3'd7)
                 state_d = (cnt_q == CW'(FRAME_BYTES)) ? HOLD : LOAD;
        HOLD:  if (div_last) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Pin values are computed here one cycle ahead so SCLK/MOSI/SS come straight from flops.
  always_comb begin
    div_d  = div_q;
    bit_d  = bit_q;
    cnt_d  = cnt_q;
    sr_d   = sr_q;
    sclk_d = sclk_q;
    ss_d   = ss_q;
    done_d = 1'b0;
`ifdef SPI_MISO_CAPTURE_EN
    rxsr_d = rxsr_q;
    rxd_d  = rxd_q;
    rxv_d  = 1'b0;
`endif
    if (state_q != IDLE && abort) begin
      div_d  = '0;
      bit_d  = '0;
      sr_d   = '0;
      sclk_d = 1'b0;
      ss_d   = 1'b1;
    end else begin
      unique case (state_q)
        IDLE: begin
          sclk_d = 1'b0;
          ss_d   = 1'b1;
          sr_d   = '0;
          div_d  = '0;
          bit_d  = '0;
          if (start && !abort) begin
            ss_d  = 1'b0;
            cnt_d = '0;
          end
        end
        SETUP, HOLD: begin
          if (div_last) begin
            div_d = '0;
            if (state_q == HOLD) begin
              ss_d   = 1'b1;
              done_d = 1'b1;
            end
          end else begin
            div_d = div_q + 8'd1;
          end
        end
        LOAD: begin
          if (tx_valid) begin
            sr_d  = tx_data;
            cnt_d = cnt_q + CW'(1);
            div_d = '0;
            bit_d = '0;
          end
        end
        SHIFT: begin
          if (div_last) begin
            div_d = '0;
            if (!sclk_q) begin
              sclk_d = 1'b1;
`ifdef SPI_MISO_CAPTURE_EN
              rxsr_d = {rxsr_q[6:0], MISO};
              if (bit_q == 3'd7) begin
                rxd_d = {rxsr_q[6:0], MISO};
                rxv_d = 1'b1;
              end
`endif
            end else begin
              sclk_d = 1'b0;
              sr_d   = {sr_q[6:0], 1'b0};
              bit_d  = bit_q + 3'd1;
            end
          end else begin
            div_d = div_q + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign tx_ready = (state_q == LOAD);
  assign busy     = (state_q != IDLE);
  assign done     = done_q;
  assign SCLK     = sclk_q;
  assign MOSI     = sr_q[7];
  assign SS       = ss_q;

`ifdef SPI_MISO_CAPTURE_EN
  assign rx_data  = rxd_q;
  assign rx_valid = rxv_q;
`else
  logic unused_miso;
  assign unused_miso = MISO;
  assign rx_data     = '0;
  assign rx_valid    = 1'b0;
`endif

endmodule

// File: tb/tb_spi_config_master.sv
// Directed bench for spi_config_master with CLK_DIV=2, FRAME_BYTES=3 and MISO looped to MOSI.
// Receive checks follow SPI_MISO_CAPTURE_EN: captured bytes when defined, constant zero otherwise.
module tb_spi_config_master;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, busy, done, rx_valid;
  logic [7:0] rx_data;
  logic       SCLK, MOSI, SS, MISO;

  int total = 0;
  int bad   = 0;

  int          sclk_rises;
  int          ss_low;
  int          done_cnt;
  int          rx_cnt;
  logic [7:0]  rx_log [8];
  logic [23:0] mosi_sh;
  logic        prev_sclk;

  assign MISO = MOSI;

  spi_config_master #(.CLK_DIV(2), .FRAME_BYTES(3)) dut (
    .system_clock(clk), .reset(reset), .start(start), .abort(abort),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .busy(busy), .done(done), .rx_data(rx_data), .rx_valid(rx_valid),
    .SCLK(SCLK), .MOSI(MOSI), .SS(SS), .MISO(MISO)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (SCLK === 1'b1 && prev_sclk === 1'b0) begin
      sclk_rises = sclk_rises + 1;
      mosi_sh    = {mosi_sh[22:0], MOSI};
    end
    prev_sclk = SCLK;
    if (SS === 1'b0) ss_low = ss_low + 1;
    if (done === 1'b1) done_cnt = done_cnt + 1;
    if (rx_valid === 1'b1) begin
      if (rx_cnt < 8) rx_log[rx_cnt] = rx_data;
      rx_cnt = rx_cnt + 1;
    end
  end

  task automatic clear_mon();
    sclk_rises = 0; ss_low = 0; done_cnt = 0; rx_cnt = 0; mosi_sh = '0;
    for (int i = 0; i < 8; i++) rx_log[i] = 8'h00;
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  // Waits for LOAD, optionally stalls with tx_valid low, then completes one handshake.
  task automatic put_byte(input logic [7:0] b, input int stall);
    int n;
    n = 0;
    while (tx_ready !== 1'b1 && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) begin
      total++; bad++;
      $display("FAIL put_byte_timeout byte=%h", b);
      return;
    end
    for (int i = 0; i < stall; i++) begin
      total++;
      if (SCLK !== 1'b0 || SS !== 1'b0) begin
        bad++;
        $display("FAIL stall_pins cycle=%0d got SCLK=%b SS=%b exp SCLK=0 SS=0", i, SCLK, SS);
      end
      @(negedge clk);
    end
    tx_data  = b;
    tx_valid = 1'b1;
    @(posedge clk);
    #1;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (done_cnt == 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (n >= 400) begin
      total++; bad++;
      $display("FAIL done_timeout got=0 exp=1");
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    total++;
    if ({SS, SCLK, MOSI, tx_ready, busy, done, rx_valid} !== 7'b1000000 || rx_data !== 8'h00) begin
      bad++;
      $display("FAIL reset_state got=%b rx=%h exp=1000000 rx=00",
               {SS, SCLK, MOSI, tx_ready, busy, done, rx_valid}, rx_data);
    end
  endtask

  task automatic test_frame();
    clear_mon();
    pulse_start();
    put_byte(8'hA5, 0);
    put_byte(8'h3C, 0);
    put_byte(8'hFF, 0);
    wait_done();
    total++;
    if (sclk_rises !== 24) begin bad++; $display("FAIL frame_rises got=%0d exp=24", sclk_rises); end
    total++;
    if (mosi_sh !== 24'hA53CFF) begin bad++; $display("FAIL frame_mosi got=%h exp=a53cff", mosi_sh); end
    total++;
    if (ss_low !== 103) begin bad++; $display("FAIL frame_ss_low got=%0d exp=103", ss_low); end
    total++;
    if (done_cnt !== 1) begin bad++; $display("FAIL frame_done got=%0d exp=1", done_cnt); end
`ifdef SPI_MISO_CAPTURE_EN
    total++;
    if (rx_cnt !== 3 || rx_log[0] !== 8'hA5 || rx_log[1] !== 8'h3C || rx_log[2] !== 8'hFF) begin
      bad++;
      $display("FAIL frame_rx got=%0d %h %h %h exp=3 a5 3c ff", rx_cnt, rx_log[0], rx_log[1], rx_log[2]);
    end
`else
    total++;
    if (rx_cnt !== 0 || rx_data !== 8'h00) begin
      bad++;
      $display("FAIL frame_rx_off got=%0d data=%h exp=0 data=00", rx_cnt, rx_data);
    end
`endif
  endtask

  task automatic test_stall();
    clear_mon();
    pulse_start();
    put_byte(8'hA5, 0);
    put_byte(8'h3C, 10);
    put_byte(8'hFF, 0);
    wait_done();
    total++;
    if (mosi_sh !== 24'hA53CFF) begin bad++; $display("FAIL stall_mosi got=%h exp=a53cff", mosi_sh); end
    total++;
    if (ss_low !== 113) begin bad++; $display("FAIL stall_ss_low got=%0d exp=113", ss_low); end
    total++;
    if (done_cnt !== 1) begin bad++; $display("FAIL stall_done got=%0d exp=1", done_cnt); end
  endtask

  task automatic test_abort();
    int n;
    clear_mon();
    pulse_start();
    put_byte(8'hA5, 0);
    put_byte(8'h3C, 0);
    n = 0;
    while (sclk_rises < 12 && n < 200) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (sclk_rises !== 12) begin bad++; $display("FAIL abort_reach got=%0d exp=12", sclk_rises); end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    total++;
    if ({SS, SCLK, busy, MOSI} !== 4'b1000) begin
      bad++;
      $display("FAIL abort_pins got=%b exp=1000", {SS, SCLK, busy, MOSI});
    end
    repeat (40) @(negedge clk);
    total++;
    if (sclk_rises !== 12 || mosi_sh[11:0] !== 12'hA53) begin
      bad++;
      $display("FAIL abort_sclk got=%0d bits=%h exp=12 bits=a53", sclk_rises, mosi_sh[11:0]);
    end
    total++;
    if (done_cnt !== 0) begin bad++; $display("FAIL abort_done got=%0d exp=0", done_cnt); end
`ifdef SPI_MISO_CAPTURE_EN
    total++;
    if (rx_cnt !== 1 || rx_log[0] !== 8'hA5) begin
      bad++;
      $display("FAIL abort_rx got=%0d %h exp=1 a5", rx_cnt, rx_log[0]);
    end
`endif
  endtask

  task automatic test_reset_midframe();
    clear_mon();
    pulse_start();
    put_byte(8'hA5, 0);
    repeat (5) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    total++;
    if ({SS, SCLK, MOSI, tx_ready, busy, done, rx_valid} !== 7'b1000000 || rx_data !== 8'h00) begin
      bad++;
      $display("FAIL async_reset got=%b rx=%h exp=1000000 rx=00",
               {SS, SCLK, MOSI, tx_ready, busy, done, rx_valid}, rx_data);
    end
    @(negedge clk);
    @(negedge clk) reset = 1'b0;
    clear_mon();
    repeat (10) @(negedge clk);
    total++;
    if (ss_low !== 0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_no_restart got ss_low=%0d busy=%b exp 0 0", ss_low, busy);
    end
    clear_mon();
    pulse_start();
    put_byte(8'h5A, 0);
    put_byte(8'h81, 0);
    put_byte(8'h00, 0);
    wait_done();
    total++;
    if (mosi_sh !== 24'h5A8100 || done_cnt !== 1) begin
      bad++;
      $display("FAIL post_reset_frame got=%h done=%0d exp=5a8100 done=1", mosi_sh, done_cnt);
    end
`ifdef SPI_MISO_CAPTURE_EN
    total++;
    if (rx_cnt !== 3 || rx_log[0] !== 8'h5A || rx_log[1] !== 8'h81 || rx_log[2] !== 8'h00) begin
      bad++;
      $display("FAIL capture_rx got=%0d %h %h %h exp=3 5a 81 00", rx_cnt, rx_log[0], rx_log[1], rx_log[2]);
    end
`endif
  endtask

  task automatic test_start_ignored();
    clear_mon();
    pulse_start();
    put_byte(8'hA5, 0);
    pulse_start();
    put_byte(8'h3C, 0);
    put_byte(8'hFF, 0);
    wait_done();
    repeat (20) @(negedge clk);
    total++;
    if (ss_low !== 103 || done_cnt !== 1 || sclk_rises !== 24) begin
      bad++;
      $display("FAIL start_while_busy got ss_low=%0d done=%0d rises=%0d exp 103 1 24",
               ss_low, done_cnt, sclk_rises);
    end
    clear_mon();
    @(negedge clk);
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    repeat (10) @(negedge clk);
    total++;
    if (ss_low !== 0 || busy !== 1'b0 || SS !== 1'b1) begin
      bad++;
      $display("FAIL start_abort_idle got ss_low=%0d busy=%b SS=%b exp 0 0 1", ss_low, busy, SS);
    end
  endtask

  initial begin
    prev_sclk = 1'b0;
    clear_mon();
    test_reset();
    test_frame();
    test_stall();
    test_abort();
    test_reset_midframe();
    test_start_ignored();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spi_config_master.md
SPI_CONFIG_MASTER -- requirements
Module: spi_config_master

Interface
REQ-001 SHALL have parameter CLK_DIV, default 4, meaning system_clock cycles per SCLK half-period (legal range 1..255).
REQ-002 SHALL have parameter FRAME_BYTES, default 215, meaning bytes sent per SS-low frame (legal range 1..1023).
REQ-003 SHALL have port system_clock, input, 1 bit: the single clock.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port start, input, 1 bit: frame request, sampled only in IDLE.
REQ-006 SHALL have port abort, input, 1 bit: terminates any frame in progress.
REQ-007 SHALL have port tx_data, input, 8 bits: next byte to send.
REQ-008 SHALL have port tx_valid, input, 1 bit; and port tx_ready, output, 1 bit: byte handshake, transfer when both are high on a clock edge.
REQ-009 SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-010 SHALL have port done, output, 1 bit: one-cycle pulse on normal frame completion.
REQ-011 SHALL have port rx_data, output, 8 bits; and port rx_valid, output, 1 bit: captured MISO byte.
REQ-012 SHALL have ports SCLK, output, 1; MOSI, output, 1; SS, output, 1 (active-low); MISO, input, 1.

Function
REQ-013 SHALL implement SPI mode 0, MSB first: MOSI changes only while SCLK is low; MISO is sampled on the system_clock edge that raises SCLK.
REQ-014 SHALL drive SCLK, MOSI and SS directly from flip-flops, with no combinational path to the pins.
REQ-015 SHALL use FSM states IDLE, SETUP, LOAD, SHIFT, HOLD.
REQ-016 IDLE: SS=1, SCLK=0, MOSI=0, tx_ready=0. start=1 with abort=0 goes to SETUP, sets SS=0 and clears the byte counter.
REQ-017 SETUP: holds SS low with SCLK low for CLK_DIV cycles, then goes to LOAD.
REQ-018 LOAD: tx_ready=1 and SCLK=0. On handshake, loads tx_data into the shift register, drives MOSI=tx_data[7], increments the byte counter, and goes to SHIFT. While tx_valid=0, it stalls indefinitely with SS held low.
REQ-019 SHIFT: runs 8 SCLK periods of CLK_DIV low cycles followed by CLK_DIV high cycles. On each falling edge it shifts MOSI to the next bit. After the 8th falling edge it goes to HOLD if counter==FRAME_BYTES, else to LOAD.
REQ-020 Unstalled byte time SHALL be exactly 1 + 16*CLK_DIV cycles.
REQ-021 HOLD: keeps SS low and SCLK low for CLK_DIV cycles, then enters IDLE with SS=1 and done=1 for that single cycle.
REQ-022 start SHALL be ignored while busy=1.
REQ-023 abort=1 in any non-IDLE state SHALL, on the next edge, force IDLE with SS=1, SCLK=0 and MOSI=0; no done pulse; no rx_valid for a partial byte.
REQ-024 If start and abort are high together in IDLE, abort SHALL win and no frame starts.
REQ-025 The byte counter width SHALL be ceil(log2(FRAME_BYTES+1)) bits; it never wraps within a frame.
REQ-026 tx_ready SHALL be low in every state except LOAD; tx_data is ignored when no handshake occurs.

Reset
REQ-027 Asserting reset SHALL immediately force IDLE with SS=1, SCLK=0, MOSI=0, tx_ready=0, busy=0, done=0, rx_valid=0, rx_data=0x00, and shift register and counter at 0, including mid-frame.
REQ-028 After reset release, the first frame SHALL need a new start.

Configuration
REQ-029 With macro SPI_MISO_CAPTURE_EN defined, MISO bits SHALL shift into an rx register. On the 8th rising SCLK edge of each byte, rx_data is updated and rx_valid pulses for one cycle. rx_data holds its value until the next byte.
REQ-030 Without SPI_MISO_CAPTURE_EN, MISO SHALL be unused, and rx_data=0x00 and rx_valid=0 constantly.

Verification
REQ-031 CLK_DIV=2, FRAME_BYTES=3, bytes 0xA5,0x3C,0xFF presented back-to-back -> MOSI sampled at 24 SCLK rises = A5 3C FF MSB-first; SS low for 2+3*33+2 cycles; one done pulse.
REQ-032 Same configuration with tx_valid held low 10 cycles before byte 2 -> SCLK stays low and SS stays low during the stall; sampled data is unchanged; frame ends with done.
REQ-033 abort asserted after the 4th SCLK rise of byte 2 -> next cycle SS=1, SCLK=0, busy=0; no done; no further SCLK edges.
REQ-034 reset asserted mid-byte -> outputs at reset values asynchronously; start after release yields a full correct frame.
REQ-035 With SPI_MISO_CAPTURE_EN, MISO looped to MOSI and bytes 0x5A,0x81,0x00 -> rx_valid pulses 3 times with rx_data 0x5A, 0x81, 0x00.
REQ-036 start pulsed while busy, and start+abort together in IDLE -> no new frame, SS unchanged.
